// File: rtl/timestable_arbiter_if.sv
// Bundle of requester handshakes and the shared timestable lookup port.
// slave is the arbiter side; master is the clients plus the timestable.
interface timestable_arbiter_if #(
    parameter int DATA_W = 3,
    parameter int RES_W  = 6
);
    logic              req0;
    logic [DATA_W-1:0] a0;
    logic [DATA_W-1:0] b0;
    logic              ack0;
    logic              res_valid0;
    logic              req1;
    logic [DATA_W-1:0] a1;
    logic [DATA_W-1:0] b1;
    logic              ack1;
    logic              res_valid1;
    logic [RES_W-1:0]  res_data;
    logic [DATA_W-1:0] tt_a;
    logic [DATA_W-1:0] tt_b;
    logic              tt_read;
    logic [RES_W-1:0]  tt_result;
    logic              busy;

    modport slave (
        input  req0, a0, b0, req1, a1, b1, tt_result,
        output ack0, res_valid0, ack1, res_valid1, res_data,
               tt_a, tt_b, tt_read, busy
    );

    modport master (
        output req0, a0, b0, req1, a1, b1, tt_result,
        input  ack0, res_valid0, ack1, res_valid1, res_data,
               tt_a, tt_b, tt_read, busy
    );
endinterface

// File: rtl/timestable_arbiter.sv
// Round-robin arbiter that shares one timestable lookup between two requesters,
// waits the lookup's read latency and returns the product with a valid pulse.
module timestable_arbiter #(
    parameter int DATA_W = 3,
    parameter int RES_W  = 6,
    parameter int RD_LAT = 1
) (
    input logic                 clk,
    input logic                 rst,
    timestable_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    logic [1:0]        state;
    logic [1:0]        cnt;
    logic              owner;
    logic              last;
    logic              grant_any;
    logic              grant_sel;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant_any = bus.req0 | bus.req1;
        grant_sel = 1'b0;
        if (bus.req0 && bus.req1) begin
            grant_sel = ~last;
        end else if (bus.req1) begin
            grant_sel = 1'b1;
        end
        sel_a = grant_sel ? bus.a1 : bus.a0;
        sel_b = grant_sel ? bus.b1 : bus.b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= 2'd0;
            owner          <= 1'b0;
            last           <= 1'b1;
            bus.ack0       <= 1'b0;
            bus.ack1       <= 1'b0;
            bus.res_valid0 <= 1'b0;
            bus.res_valid1 <= 1'b0;
            bus.res_data   <= '0;
            bus.tt_a       <= '0;
            bus.tt_b       <= '0;
            bus.tt_read    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.res_valid0 <= 1'b0;
                    bus.res_valid1 <= 1'b0;
                    if (grant_any) begin
                        bus.tt_a    <= sel_a;
                        bus.tt_b    <= sel_b;
                        bus.tt_read <= 1'b1;
                        bus.ack0    <= ~grant_sel;
                        bus.ack1    <= grant_sel;
                        owner       <= grant_sel;
                        last        <= grant_sel;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.tt_read <= 1'b0;
                    bus.ack0    <= 1'b0;
                    bus.ack1    <= 1'b0;
                    cnt         <= CNT_INIT;
                    state       <= WAIT;
                end
                WAIT: begin
                    if (cnt != 2'd0) begin
                        cnt <= cnt - 2'd1;
                    end else begin
                        bus.res_data   <= RES_W'(bus.tt_result);
                        bus.res_valid0 <= ~owner;
                        bus.res_valid1 <= owner;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_timestable_arbiter.sv
// Randomised bench: requester drivers feed job queues, a negedge monitor checks
// grants, lookup port and returned products against a transaction-level model.
module tb_timestable_arbiter;

    localparam int DATA_W = 3;
    localparam int RES_W  = 6;
    localparam int RD_LAT = 1;

    typedef struct {
        int a;
        int b;
        int gap;
    } job_t;

    typedef struct {
        bit owner;
        int due;
    } pend_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    timestable_arbiter_if #(.DATA_W(DATA_W), .RES_W(RES_W)) bus_if ();

    timestable_arbiter #(.DATA_W(DATA_W), .RES_W(RES_W), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    // Behavioural timestable: registered product one cycle after the read edge.
    always @(posedge clk) begin
        if (bus_if.tt_read) begin
            bus_if.tt_result <= RES_W'(bus_if.tt_a) * RES_W'(bus_if.tt_b);
        end
    end

    job_t jobs0[$];
    job_t jobs1[$];
    int   exp0[$];
    int   exp1[$];
    int   wait0 = 0;
    int   wait1 = 0;
    bit   stim_done = 1'b0;
    bit   stim_timeout = 1'b0;

    task automatic applyStimulus(input int who, input int a, input int b, input int gap);
        job_t j;
        j.a = a;
        j.b = b;
        j.gap = gap;
        if (who == 0) jobs0.push_back(j);
        else          jobs1.push_back(j);
    endtask

    task automatic stepCycle();
        job_t j;
        @(posedge clk);
        #1;
        if (bus_if.ack0) bus_if.req0 = 1'b0;
        if (bus_if.ack1) bus_if.req1 = 1'b0;
        if (!rst) begin
            if (!bus_if.req0 && jobs0.size() > 0) begin
                if (wait0 < jobs0[0].gap) begin
                    wait0++;
                end else begin
                    j = jobs0.pop_front();
                    wait0 = 0;
                    bus_if.a0 = DATA_W'(j.a);
                    bus_if.b0 = DATA_W'(j.b);
                    bus_if.req0 = 1'b1;
                    exp0.push_back(j.a * j.b);
                end
            end
            if (!bus_if.req1 && jobs1.size() > 0) begin
                if (wait1 < jobs1[0].gap) begin
                    wait1++;
                end else begin
                    j = jobs1.pop_front();
                    wait1 = 0;
                    bus_if.a1 = DATA_W'(j.a);
                    bus_if.b1 = DATA_W'(j.b);
                    bus_if.req1 = 1'b1;
                    exp1.push_back(j.a * j.b);
                end
            end
        end
    endtask

    task automatic resetDut(input int n);
        rst = 1'b1;
        bus_if.req0 = 1'b0;
        bus_if.req1 = 1'b0;
        jobs0.delete();
        jobs1.delete();
        wait0 = 0;
        wait1 = 0;
        repeat (n) stepCycle();
        rst = 1'b0;
    endtask

    task automatic runUntilIdle(input int bound);
        int n;
        n = 0;
        while ((jobs0.size() > 0 || jobs1.size() > 0 || bus_if.req0 || bus_if.req1 ||
                bus_if.busy) && n < bound) begin
            stepCycle();
            n++;
        end
        if (n >= bound) stim_timeout = 1'b1;
        repeat (3) stepCycle();
    endtask

    initial begin
        int n;
        bus_if.req0 = 1'b0;
        bus_if.req1 = 1'b0;
        bus_if.a0 = '0;
        bus_if.b0 = '0;
        bus_if.a1 = '0;
        bus_if.b1 = '0;
        resetDut(2);

        $display("[TB] single request");
        applyStimulus(0, 3, 5, 0);
        runUntilIdle(100);

        $display("[TB] tie after reset");
        resetDut(2);
        applyStimulus(0, 7, 7, 0);
        applyStimulus(1, 2, 6, 0);
        runUntilIdle(100);

        $display("[TB] sustained contention");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 7, 7, 0);
            applyStimulus(1, 2, 6, 0);
        end
        runUntilIdle(200);

        $display("[TB] exhaustive sweep on requester 1");
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                applyStimulus(1, a, b, int'($urandom_range(0, 2)));
            end
        end
        runUntilIdle(1000);

        $display("[TB] random mixed traffic");
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 3)));
            applyStimulus(1, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 3)));
        end
        runUntilIdle(2000);

        $display("[TB] reset during wait");
        applyStimulus(0, 3, 3, 0);
        n = 0;
        while (!bus_if.ack0 && n < 50) begin
            stepCycle();
            n++;
        end
        if (n >= 50) stim_timeout = 1'b1;
        stepCycle();
        resetDut(1);
        applyStimulus(1, 4, 4, 0);
        runUntilIdle(100);

        $display("[TB] idle hold");
        applyStimulus(0, 3, 5, 0);
        runUntilIdle(100);
        repeat (10) stepCycle();

        stim_done = 1'b1;
        forever stepCycle();
    end

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    int    rd0 = 0;
    int    rd1 = 0;
    bit    armed = 1'b0;
    bit    p_rst = 1'b0;
    bit    p_req0 = 1'b0;
    bit    p_req1 = 1'b0;
    bit    m_last = 1'b1;
    int    p_a0 = 0, p_b0 = 0, p_a1 = 0, p_b1 = 0;
    int    m_tta = 0, m_ttb = 0;
    int    m_next = 0;
    int    m_busy_until = 0;
    int    m_res = 0;
    pend_t pend[$];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, actual, expected);
        end
    endtask

    // Model: a grant may start RD_LAT+2 cycles after the previous one; its
    // result is due RD_LAT+1 cycles after the ack becomes visible.
    always @(negedge clk) begin
        bit    g0, g1, v0, v1;
        pend_t pe;
        cyc++;
        if (p_rst) begin
            armed = 1'b1;
            pend.delete();
            rd0 = exp0.size();
            rd1 = exp1.size();
            m_last = 1'b1;
            m_next = cyc + 1;
            m_busy_until = cyc - 1;
            m_res = 0;
            m_tta = 0;
            m_ttb = 0;
            checkOutput("reset_ctrl", int'({bus_if.ack1, bus_if.ack0, bus_if.res_valid1,
                                            bus_if.res_valid0, bus_if.tt_read, bus_if.busy}), 0);
            checkOutput("reset_res_data", int'(bus_if.res_data), 0);
            checkOutput("reset_tt_ab", int'({bus_if.tt_a, bus_if.tt_b}), 0);
        end else if (armed) begin
            g0 = 1'b0;
            g1 = 1'b0;
            if (cyc >= m_next && (p_req0 || p_req1)) begin
                if (p_req0 && p_req1) begin
                    g1 = (m_last == 1'b0);
                    g0 = ~g1;
                end else begin
                    g0 = p_req0;
                    g1 = p_req1;
                end
            end
            checkOutput("ack", int'({bus_if.ack1, bus_if.ack0}), int'({g1, g0}));
            if (g0 || g1) begin
                m_last = g1;
                m_next = cyc + RD_LAT + 2;
                m_busy_until = cyc + RD_LAT;
                m_tta = g1 ? p_a1 : p_a0;
                m_ttb = g1 ? p_b1 : p_b0;
                pend.push_back('{g1, cyc + RD_LAT + 1});
            end
            checkOutput("tt_read", int'(bus_if.tt_read), int'(g0 | g1));
            checkOutput("tt_a", int'(bus_if.tt_a), m_tta);
            checkOutput("tt_b", int'(bus_if.tt_b), m_ttb);
            checkOutput("busy", int'(bus_if.busy), int'(cyc <= m_busy_until));
            v0 = 1'b0;
            v1 = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                pe = pend.pop_front();
                v1 = pe.owner;
                v0 = ~pe.owner;
                if (pe.owner && rd1 < exp1.size()) begin
                    m_res = exp1[rd1];
                    rd1++;
                end else if (!pe.owner && rd0 < exp0.size()) begin
                    m_res = exp0[rd0];
                    rd0++;
                end
            end
            checkOutput("res_valid", int'({bus_if.res_valid1, bus_if.res_valid0}), int'({v1, v0}));
            checkOutput("res_data", int'(bus_if.res_data), m_res);
        end
        p_rst = rst;
        p_req0 = bus_if.req0;
        p_req1 = bus_if.req1;
        p_a0 = int'(bus_if.a0);
        p_b0 = int'(bus_if.b0);
        p_a1 = int'(bus_if.a1);
        p_b1 = int'(bus_if.b1);
        if (stim_done || cyc > 40000) begin
            checkOutput("stimulus_complete", int'(stim_done), 1);
            checkOutput("stimulus_timeout", int'(stim_timeout), 0);
            checkOutput("drain0", rd0, exp0.size());
            checkOutput("drain1", rd1, exp1.size());
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

endmodule
